// File: rtl/cycle_schedule_ctrl.sv
// cycle_schedule_ctrl
//   Turns global synchronized time into a cycle schedule. The scheduler
//   waits for the operation base time, then emits one pulse per cycle
//   boundary, a wrapping cycle index and the offset into the current cycle.
//   Large forward time jumps are absorbed by stepping whole cycles (catch-up).
//   A backward jump, or catch-up that runs too long, raises a sticky time
//   error.
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   iv_syn_clk           global time (ns)
//   i_enable             scheduler enable; low forces IDLE
//   iv_cycle_length      configured cycle length (ns)
//   iv_oper_base         configured operation base time (ns)
//   i_cfg_update         one-clock pulse that samples the configuration
//   o_cycle_start        one-clock pulse at each cycle boundary
//   ov_cycle_id          cycle index
//   ov_cycle_offset      time minus current cycle base (RUN only)
//   ov_state             0 IDLE, 1 WAIT, 2 RUN, 3 CATCHUP
//   o_cfg_err            active length is zero
//   o_time_err           sticky time error
module cycle_schedule_ctrl #(
  parameter int MAX_CATCHUP = 1024,
  parameter int ID_WIDTH    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [63:0]         iv_syn_clk,
  input  logic                i_enable,
  input  logic [31:0]         iv_cycle_length,
  input  logic [63:0]         iv_oper_base,
  input  logic                i_cfg_update,
  output logic                o_cycle_start,
  output logic [ID_WIDTH-1:0] ov_cycle_id,
  output logic [31:0]         ov_cycle_offset,
  output logic [1:0]          ov_state,
  output logic                o_cfg_err,
  output logic                o_time_err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RUN = 2'd2, S_CATCH = 2'd3} state_t;

  localparam int CW = $clog2(MAX_CATCHUP + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CATCHUP - 1);

  state_t              state_q;
  logic [31:0]         len_q, pend_len_q;
  logic [63:0]         base_q, pend_base_q, cbase_q;
  logic                pend_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [CW-1:0]       cnt_q;
  logic                start_q, cfg_err_q, time_err_q;
  logic [31:0]         off_q;

  // Distance into the current cycle, and distance past the operation base.
  logic [63:0] diff, wdiff;
  logic        diff_hi, ge_len, ge_2len, back, w_lt;

  always_comb begin
    diff    = iv_syn_clk - cbase_q;
    wdiff   = iv_syn_clk - base_q;
    // Anything above bit 32 already exceeds 2*length for any 32-bit length.
    diff_hi = |diff[63:33];
    ge_len  = diff_hi || (diff[32:0] >= {1'b0, len_q});
    ge_2len = diff_hi || (diff[32:0] >= {len_q, 1'b0});
    back    = iv_syn_clk < cbase_q;
    w_lt    = !(|wdiff[63:32]) && (wdiff[31:0] < len_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      len_q       <= 32'd100000;
      base_q      <= 64'd60000000000;
      pend_len_q  <= '0;
      pend_base_q <= '0;
      pend_q      <= 1'b0;
      cbase_q     <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      off_q       <= '0;
      cfg_err_q   <= 1'b0;
      time_err_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      // Clear first so an error raised on the same edge takes precedence.
      if (i_cfg_update) time_err_q <= 1'b0;

      if (!i_enable) begin
        state_q <= S_IDLE;
        id_q    <= '0;
        off_q   <= '0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            off_q <= '0;
            if (len_q != 32'd0 && !time_err_q) state_q <= S_WAIT;
          end
          S_WAIT: begin
            off_q <= '0;
            if (iv_syn_clk >= base_q) begin
              cbase_q <= base_q;
              id_q    <= '0;
              cnt_q   <= '0;
              if (w_lt) begin
                state_q <= S_RUN;
                start_q <= 1'b1;
                off_q   <= wdiff[31:0];
              end else begin
                state_q <= S_CATCH;
              end
            end
          end
          S_RUN: begin
            if (back) begin
              time_err_q <= 1'b1;
              state_q    <= S_WAIT;
              id_q       <= '0;
              off_q      <= '0;
            end else if (ge_2len) begin
              state_q <= S_CATCH;
              cnt_q   <= '0;
              off_q   <= '0;
            end else if (ge_len) begin
              cbase_q <= cbase_q + {32'd0, len_q};
              id_q    <= id_q + ID_WIDTH'(1);
              start_q <= 1'b1;
              off_q   <= diff[31:0] - len_q;
              if (pend_q) begin
                len_q     <= pend_len_q;
                base_q    <= pend_base_q;
                pend_q    <= 1'b0;
                cfg_err_q <= (pend_len_q == 32'd0);
              end
            end else begin
              off_q <= diff[31:0];
            end
          end
          S_CATCH: begin
            // Every catch-up clock advances one whole cycle, exit included.
            cbase_q <= cbase_q + {32'd0, len_q};
            id_q    <= id_q + ID_WIDTH'(1);
            off_q   <= '0;
            if (!ge_2len) begin
              state_q <= S_RUN;
              start_q <= 1'b1;
              off_q   <= diff[31:0] - len_q;
              cnt_q   <= '0;
              if (pend_q) begin
                len_q     <= pend_len_q;
                base_q    <= pend_base_q;
                pend_q    <= 1'b0;
                cfg_err_q <= (pend_len_q == 32'd0);
              end
            end else if (cnt_q == CNT_LAST) begin
              time_err_q <= 1'b1;
              state_q    <= S_IDLE;
              id_q       <= '0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end

      // Configuration sampling; placed after the FSM so a new pending value
      // written on a boundary edge survives the apply on that same edge.
      if (i_cfg_update) begin
        if (state_q == S_IDLE || state_q == S_WAIT) begin
          len_q     <= iv_cycle_length;
          base_q    <= iv_oper_base;
          cfg_err_q <= (iv_cycle_length == 32'd0);
        end else begin
          pend_len_q  <= iv_cycle_length;
          pend_base_q <= iv_oper_base;
          pend_q      <= 1'b1;
        end
      end
    end
  end

  assign o_cycle_start   = start_q;
  assign ov_cycle_id     = id_q;
  assign ov_cycle_offset = off_q;
  assign ov_state        = state_q;
  assign o_cfg_err       = cfg_err_q;
  assign o_time_err      = time_err_q;

endmodule

// File: tb/tb_cycle_schedule_ctrl.sv
// Bench for cycle_schedule_ctrl. Each tick drives one cycle of inputs and
// queues the outputs expected after that edge; the next tick pops and
// compares them. A second instance with MAX_CATCHUP=4 shares all inputs
// and is compared only where the catch-up limit is exercised.
module tb_cycle_schedule_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, upd;
  logic [63:0] syn, base;
  logic [31:0] len;

  logic        cs, cerr, terr;
  logic [15:0] cid;
  logic [31:0] coff;
  logic [1:0]  cst;
  logic        l_cs, l_cerr, l_terr;
  logic [15:0] l_id;
  logic [31:0] l_off;
  logic [1:0]  l_st;

  cycle_schedule_ctrl dut (
    .i_clk(clk), .i_rst(rst), .iv_syn_clk(syn), .i_enable(en),
    .iv_cycle_length(len), .iv_oper_base(base), .i_cfg_update(upd),
    .o_cycle_start(cs), .ov_cycle_id(cid), .ov_cycle_offset(coff),
    .ov_state(cst), .o_cfg_err(cerr), .o_time_err(terr)
  );

  cycle_schedule_ctrl #(.MAX_CATCHUP(4)) dut_lim (
    .i_clk(clk), .i_rst(rst), .iv_syn_clk(syn), .i_enable(en),
    .iv_cycle_length(len), .iv_oper_base(base), .i_cfg_update(upd),
    .o_cycle_start(l_cs), .ov_cycle_id(l_id), .ov_cycle_offset(l_off),
    .ov_state(l_st), .o_cfg_err(l_cerr), .o_time_err(l_terr)
  );

  typedef struct {
    logic        rst, en, upd;
    logic [31:0] len;
    logic [63:0] base, syn;
    bit          chk;
    logic        s;
    logic [15:0] id;
    logic [31:0] off;
    logic [1:0]  st;
    logic        te, ce;
    bit          chkl;
    logic [1:0]  lst;
    logic        lte;
  } ent_t;

  ent_t q[$];
  int nchk = 0;
  int nerr = 0;

  // Current drive and limiter expectations, set by the sequence below.
  logic        g_rst = 1'b1, g_en = 1'b0, g_upd = 1'b0, g_ce = 1'b0;
  logic [31:0] g_len = '0;
  logic [63:0] g_base = '0;
  bit          g_chkl = 1'b0;
  logic [1:0]  g_lst = '0;
  logic        g_lte = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tk(input logic [63:0] t, input bit c, input logic s, input int id,
                    input int off, input int st, input logic te);
    ent_t e, p;
    e.rst = g_rst; e.en = g_en; e.upd = g_upd; e.len = g_len; e.base = g_base;
    e.syn = t; e.chk = c; e.s = s; e.id = 16'(id); e.off = 32'(off);
    e.st = 2'(st); e.te = te; e.ce = g_ce;
    e.chkl = g_chkl; e.lst = g_lst; e.lte = g_lte;
    @(negedge clk);
    if (q.size() > 0) begin
      p = q.pop_front();
      if (p.chk) begin
        chk($sformatf("start@%0d", p.syn), {63'd0, cs}, {63'd0, p.s});
        chk($sformatf("id@%0d", p.syn), {48'd0, cid}, {48'd0, p.id});
        chk($sformatf("offset@%0d", p.syn), {32'd0, coff}, {32'd0, p.off});
        chk($sformatf("state@%0d", p.syn), {62'd0, cst}, {62'd0, p.st});
        chk($sformatf("time_err@%0d", p.syn), {63'd0, terr}, {63'd0, p.te});
        chk($sformatf("cfg_err@%0d", p.syn), {63'd0, cerr}, {63'd0, p.ce});
      end
      if (p.chkl) begin
        chk($sformatf("lim_state@%0d", p.syn), {62'd0, l_st}, {62'd0, p.lst});
        chk($sformatf("lim_time_err@%0d", p.syn), {63'd0, l_terr}, {63'd0, p.lte});
      end
    end
    rst = e.rst; en = e.en; upd = e.upd; len = e.len; base = e.base; syn = e.syn;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; upd = 1'b0; syn = '0; len = '0; base = '0;

    // Reset state
    tk(0, 1, 0, 0, 0, 0, 0);
    g_rst = 1'b0;

    // Basic start: base 1000, length 100, ramp by 10
    g_upd = 1'b1; g_len = 100; g_base = 1000;
    tk(900, 1, 0, 0, 0, 0, 0);
    g_upd = 1'b0; g_en = 1'b1;
    tk(900, 1, 0, 0, 0, 1, 0);
    for (int t = 910; t < 1000; t += 10) tk(t, 1, 0, 0, 0, 1, 0);
    for (int t = 1000; t <= 1310; t += 10)
      tk(t, 1, (t % 100) == 0, (t - 1000) / 100, (t - 1000) % 100, 2, 0);

    // Forward jump from 1310 to 1725: four catch-up clocks, pulse on exit
    tk(1725, 1, 0, 3, 0, 3, 0);
    for (int k = 4; k <= 6; k++) tk(1725, 1, 0, k, 0, 3, 0);
    tk(1725, 1, 1, 7, 25, 2, 0);
    tk(1730, 1, 0, 7, 30, 2, 0);

    // Backward jump below the cycle base (1700)
    tk(1750, 1, 0, 7, 50, 2, 0);
    tk(1600, 1, 0, 0, 0, 1, 1);
    tk(900, 1, 0, 0, 0, 1, 1);
    g_upd = 1'b1;
    tk(900, 1, 0, 0, 0, 1, 0);
    g_upd = 1'b0;
    tk(1000, 1, 1, 0, 0, 2, 0);

    // Length change mid-cycle: next boundary still +100, then +200
    tk(1050, 1, 0, 0, 50, 2, 0);
    g_upd = 1'b1; g_len = 200;
    tk(1060, 1, 0, 0, 60, 2, 0);
    g_upd = 1'b0;
    tk(1100, 1, 1, 1, 0, 2, 0);
    tk(1200, 1, 0, 1, 100, 2, 0);
    tk(1299, 1, 0, 1, 199, 2, 0);
    tk(1300, 1, 1, 2, 0, 2, 0);
    tk(1400, 1, 0, 2, 100, 2, 0);
    // Update on a boundary edge: boundary uses 200, 50 applies one boundary later
    g_upd = 1'b1; g_len = 50;
    tk(1500, 1, 1, 3, 0, 2, 0);
    g_upd = 1'b0;
    tk(1540, 1, 0, 3, 40, 2, 0);
    tk(1700, 1, 1, 4, 0, 2, 0);
    tk(1750, 1, 1, 5, 0, 2, 0);
    tk(1760, 1, 0, 5, 10, 2, 0);

    // Disable, then zero length in IDLE
    g_en = 1'b0;
    tk(1770, 1, 0, 0, 0, 0, 0);
    g_upd = 1'b1; g_len = 0; g_ce = 1'b1;
    tk(1770, 1, 0, 0, 0, 0, 0);
    g_upd = 1'b0; g_en = 1'b1;
    tk(1770, 1, 0, 0, 0, 0, 0);
    tk(1770, 1, 0, 0, 0, 0, 0);
    g_en = 1'b0; g_upd = 1'b1; g_len = 100; g_base = 1000; g_ce = 1'b0;
    tk(1770, 1, 0, 0, 0, 0, 0);
    g_upd = 1'b0;

    // Late start at 1550: five catch-up clocks, then one pulse, id 5 offset 50
    g_en = 1'b1;
    tk(1550, 1, 0, 0, 0, 1, 0);
    tk(1550, 1, 0, 0, 0, 3, 0);
    for (int k = 1; k <= 4; k++) tk(1550, 1, 0, k, 0, 3, 0);
    tk(1550, 1, 1, 5, 50, 2, 0);
    tk(1560, 1, 0, 5, 60, 2, 0);

    // Reset mid-operation
    g_rst = 1'b1;
    tk(1570, 1, 0, 0, 0, 0, 0);
    g_rst = 1'b0; g_en = 1'b0;

    // Catch-up limit: jump of ten cycles; limited instance errors on step 4
    g_upd = 1'b1; g_len = 100; g_base = 1000;
    tk(900, 1, 0, 0, 0, 0, 0);
    g_upd = 1'b0; g_en = 1'b1;
    tk(900, 1, 0, 0, 0, 1, 0);
    g_chkl = 1'b1; g_lst = 2; g_lte = 1'b0;
    tk(1000, 1, 1, 0, 0, 2, 0);
    g_lst = 3;
    tk(2050, 1, 0, 0, 0, 3, 0);
    for (int k = 1; k <= 10; k++) begin
      g_lst = (k < 4) ? 2'd3 : 2'd0;
      g_lte = (k >= 4);
      if (k < 10) tk(2050, 1, 0, k, 0, 3, 0);
      else        tk(2050, 1, 1, 10, 50, 2, 0);
    end
    g_lst = 0; g_lte = 1'b1;
    tk(2060, 1, 0, 10, 60, 2, 0);
    g_upd = 1'b1; g_lte = 1'b0;
    tk(2070, 1, 0, 10, 70, 2, 0);
    g_upd = 1'b0; g_lst = 1;
    tk(2080, 1, 0, 10, 80, 2, 0);
    g_chkl = 1'b0;

    // ID wrap: length 1 with time advancing 1 ns per clock
    g_rst = 1'b1;
    tk(2090, 0, 0, 0, 0, 0, 0);
    g_rst = 1'b0; g_en = 1'b0; g_upd = 1'b1; g_len = 1; g_base = 1000;
    tk(900, 0, 0, 0, 0, 0, 0);
    g_upd = 1'b0; g_en = 1'b1;
    tk(900, 1, 0, 0, 0, 1, 0);
    tk(1000, 1, 1, 0, 0, 2, 0);
    for (int k = 1; k <= 65536; k++)
      tk(64'(1000 + k), k >= 65534, 1, k % 65536, 0, 2, 0);

    g_en = 1'b0;
    tk(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/cycle_schedule_ctrl.md
Name: cycle_schedule_ctrl

Overview:
- Sequences the time-aware datapath using the cycle_length / oper_base configuration written over the HCP command path.
- Compares global synchronized time against the configured operation base and cycle length.
- Emits a one-clock cycle-start pulse, a wrapping cycle index and the in-cycle offset for the downstream gate/injection schedulers.
- Handles configuration updates at cycle boundaries and recovers from global-time jumps.

Parameters:
- MAX_CATCHUP, 1024, maximum consecutive catch-up steps before declaring a time error.
- ID_WIDTH, 16, width of the cycle index.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- iv_syn_clk  in  64  global synchronized time in ns, monotonic except on sync corrections.
- i_enable  in  1  scheduler enable.
- iv_cycle_length  in  32  configured cycle length (ns).
- iv_oper_base  in  64  configured operation base time (ns).
- i_cfg_update  in  1  one-clock pulse: sample iv_cycle_length/iv_oper_base into pending registers.
- o_cycle_start  out  1  one-clock pulse at each cycle boundary.
- ov_cycle_id  out  ID_WIDTH  current cycle index.
- ov_cycle_offset  out  32  iv_syn_clk minus current cycle base.
- ov_state  out  2  FSM state: 0 IDLE, 1 WAIT, 2 RUN, 3 CATCHUP.
- o_cfg_err  out  1  active length is zero.
- o_time_err  out  1  sticky time error.

Behaviour:
- **Clocking and reset.** Single clock domain. All outputs are registered and reflect the iv_syn_clk sampled on the previous edge.
- **Reset values.**
  - state = IDLE.
  - Active length = 100000; active base = 60000000000; pending flag = 0.
  - cycle_base = 0.
  - All outputs = 0.
- **Configuration.**
  - i_cfg_update in IDLE or WAIT: load the active registers directly and clear o_time_err.
  - i_cfg_update in RUN or CATCHUP: store pending and set the pending flag; o_time_err is also cleared.
  - Pending length is applied at the next boundary (RUN boundary or CATCHUP exit).
  - Pending base is applied at the same point but only used on the next WAIT entry.
  - A later i_cfg_update overwrites the pending values.
- **diff.** diff = iv_syn_clk − cycle_base, 64-bit unsigned.
  - Boundary compares use length and 2·length extended to 33 bits.
  - ov_cycle_offset = diff[31:0] in RUN, otherwise 0.
- **i_enable low** in any state: IDLE on the next clock, and o_cycle_start, ov_cycle_id and ov_cycle_offset go to 0. This has priority over all transitions below.
- **IDLE:** o_cfg_err = (active length == 0). Go to WAIT when i_enable && length != 0 && !o_time_err.
- **WAIT:** when iv_syn_clk ≥ active base:
  - Set cycle_base = base and id = 0.
  - If iv_syn_clk − base < length: go to RUN and pulse o_cycle_start.
  - Otherwise: go to CATCHUP.
- **RUN:** checks in this priority order.
  - iv_syn_clk < cycle_base (backward jump): set o_time_err, go to WAIT, id = 0.
  - diff ≥ 2·length: go to CATCHUP with no pulse.
  - diff ≥ length: cycle_base += length, id += 1 (wraps 2^ID_WIDTH−1 → 0), pulse o_cycle_start, apply pending.
  - Otherwise: hold.
- **CATCHUP:**
  - Each clock: cycle_base += length, id += 1, step counter += 1, no pulse.
  - If pre-step diff < 2·length: go to RUN, pulse o_cycle_start in that same output cycle, apply pending, clear the counter.
  - If the counter reaches MAX_CATCHUP: set o_time_err, go to IDLE, id = 0.
  - IDLE then stays until i_cfg_update clears o_time_err.
- **Error flags.** o_time_err is sticky; it is cleared only by i_cfg_update or i_rst.
- **Simultaneous events.** i_cfg_update on a RUN boundary clock: the boundary uses the old length, and the new value becomes pending until the next boundary.
- **Reset mid-operation.** Reset returns everything to the reset values; no pulse is emitted.

Test Plan:
1. **Basic start.** Reset, base = 1000, length = 100, enable, time ramps 900→1400 step 10.
   - Expected: first pulse when time = 1000 is sampled, id = 0.
   - Pulses at 1100/1200/1300 with id 1/2/3; offset counts 0..90 by 10.
2. **Late start.** Base = 1000, length = 100, time starts at 1550.
   - Expected: WAIT→CATCHUP for 5 clocks, then RUN with a single pulse; id = 5, offset = 50.
3. **Forward jump.** In RUN with id = 3, base 1300, time jumps 1310→1725.
   - Expected: CATCHUP; exactly one pulse on exit; id = 7, offset 25.
4. **Backward jump.** In RUN at time 1350, time steps to 1200.
   - Expected: o_time_err = 1, state WAIT, id = 0.
   - Then i_cfg_update clears the error; restart at base.
5. **Length change.** In RUN with length = 100, i_cfg_update with length = 200 mid-cycle.
   - Expected: next boundary still at +100; following boundary at +200.
   - length = 0 written in IDLE: o_cfg_err = 1, remains IDLE.
6. **Wrap and limit.**
   - ID wrap: preload id 65535 via a long run; next boundary gives id = 0.
   - MAX_CATCHUP = 4 with a jump of 10 cycles: o_time_err = 1, state IDLE.
